// File: rtl/latch_sched_pkg.sv
// Shared constants for the latch write scheduler: state encoding, bank defaults,
// op codes and the slot-select decoder.
package latch_sched_pkg;

  localparam int NSLOT_DEF = 4;
  localparam int DW_DEF    = 2;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SETUP  = 3'd1;
  localparam state_t ST_ENABLE = 3'd2;
  localparam state_t ST_HOLD   = 3'd3;
  localparam state_t ST_CLEAR  = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  function automatic logic [NSLOT_DEF-1:0] slot_mask(input logic [1:0] addr);
    slot_mask = 4'b0001 << addr;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer moves only when UPD
// accepts a grant, so an unserved request keeps its turn.
module rr_arb2 (
  input  logic       CLK,
  input  logic       ARST_N,
  input  logic [1:0] REQ,
  input  logic       UPD,
  output logic [1:0] GNT
);

  logic ptr_q;
  logic ptr_d;

  // grant decode; ptr_q names the requester that wins a tie
  always_comb begin
    case (REQ)
      2'b01:   GNT = 2'b01;
      2'b10:   GNT = 2'b10;
      2'b11:   GNT = ptr_q ? 2'b10 : 2'b01;
      default: GNT = 2'b00;
    endcase
  end

  // next pointer favours whoever was not just served
  always_comb begin
    if (UPD && (GNT != 2'b00)) begin
      ptr_d = GNT[0];
    end else begin
      ptr_d = ptr_q;
    end
  end

  // pointer register
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/latch_wr_sched.sv
// Schedules writes and clears into an external latch bank for two requesters,
// sequencing data setup, enable pulse and hold so latch timing is glitch-safe.
module latch_wr_sched
  import latch_sched_pkg::*;
#(
  parameter int NSLOT = NSLOT_DEF,
  parameter int DW    = DW_DEF,
  parameter int ENW   = 1
) (
  input  logic                CLK,
  input  logic                ARST_N,
  input  logic [1:0]          REQ,
  input  logic [1:0]          CLR,
  input  logic [3:0]          ADDR,
  input  logic [2*DW-1:0]     DATA,
  output logic [1:0]          ACK,
  output logic [DW-1:0]       LAT_D,
  output logic [NSLOT-1:0]    LAT_EN,
  output logic [NSLOT-1:0]    LAT_ARST,
  output logic                BUSY,
  output logic [NSLOT*DW-1:0] SHADOW
);

  generate
    if (ENW < 1 || ENW > 4) begin : g_bad_enw
      $error("latch_wr_sched: ENW must be in 1..4");
    end
    if (NSLOT != 4) begin : g_bad_nslot
      $error("latch_wr_sched: NSLOT must be 4");
    end
  endgenerate

  localparam logic [1:0] ENW_LAST = 2'(ENW - 1);

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                gsel_q, gsel_d;
  logic                op_q, op_d;
  logic [1:0]          addr_q, addr_d;
  logic [DW-1:0]       data_q, data_d;
  logic [DW-1:0]       lat_d_q, lat_d_d;
  logic [NSLOT-1:0]    lat_en_q, lat_en_d;
  logic [NSLOT-1:0]    lat_arst_q, lat_arst_d;
  logic [1:0]          ack_q, ack_d;
  logic                busy_q, busy_d;
  logic [NSLOT*DW-1:0] shadow_q, shadow_d;

  logic [1:0]          gnt_s;
  logic                upd_s;
  logic                gidx_s;
  logic                clr_sel_s;
  logic [1:0]          addr_sel_s;
  logic [DW-1:0]       data_sel_s;

  assign upd_s      = (state_q == ST_IDLE) && (REQ != 2'b00);
  assign gidx_s     = gnt_s[1];
  assign clr_sel_s  = gidx_s ? CLR[1] : CLR[0];
  assign addr_sel_s = gidx_s ? ADDR[3:2] : ADDR[1:0];
  assign data_sel_s = gidx_s ? DATA[2*DW-1:DW] : DATA[DW-1:0];

  rr_arb2 u_arb (
    .CLK    (CLK),
    .ARST_N (ARST_N),
    .REQ    (REQ),
    .UPD    (upd_s),
    .GNT    (gnt_s)
  );

  // sequencing FSM plus next values of the registered outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gsel_d   = gsel_q;
    op_d     = op_q;
    addr_d   = addr_q;
    data_d   = data_q;
    lat_d_d  = lat_d_q;
    shadow_d = shadow_q;

    case (state_q)
      ST_IDLE: begin
        if (upd_s) begin
          gsel_d = gidx_s;
          op_d   = clr_sel_s;
          addr_d = addr_sel_s;
          data_d = data_sel_s;
          if (clr_sel_s == OP_CLEAR) begin
            state_d = ST_CLEAR;
          end else begin
            state_d = ST_SETUP;
            lat_d_d = data_sel_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_ENABLE;
        cnt_d   = 2'd0;
      end
      ST_ENABLE: begin
        if (cnt_q == ENW_LAST) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_HOLD:  state_d = ST_DONE;
      ST_CLEAR: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // outputs are registered from the next state so they line up with state_q
    lat_en_d   = (state_d == ST_ENABLE) ? slot_mask(addr_d) : {NSLOT{1'b0}};
    lat_arst_d = (state_d == ST_CLEAR)  ? slot_mask(addr_d) : {NSLOT{1'b0}};
    ack_d      = (state_d == ST_DONE) ? (gsel_d ? 2'b10 : 2'b01) : 2'b00;
    busy_d     = (state_d != ST_IDLE);

    if (state_d == ST_DONE) begin
      for (int s = 0; s < NSLOT; s++) begin
        if (addr_q == s[1:0]) begin
          shadow_d[DW*s +: DW] = (op_q == OP_CLEAR) ? {DW{1'b0}} : data_q;
        end else begin
          shadow_d[DW*s +: DW] = shadow_q[DW*s +: DW];
        end
      end
    end else begin
      shadow_d = shadow_q;
    end
  end

  // state and output registers; reset holds every latch in clear
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      gsel_q     <= 1'b0;
      op_q       <= OP_WRITE;
      addr_q     <= 2'd0;
      data_q     <= {DW{1'b0}};
      lat_d_q    <= {DW{1'b0}};
      lat_en_q   <= {NSLOT{1'b0}};
      lat_arst_q <= {NSLOT{1'b1}};
      ack_q      <= 2'b00;
      busy_q     <= 1'b0;
      shadow_q   <= {(NSLOT*DW){1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gsel_q     <= gsel_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      lat_d_q    <= lat_d_d;
      lat_en_q   <= lat_en_d;
      lat_arst_q <= lat_arst_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      shadow_q   <= shadow_d;
    end
  end

  assign ACK      = ack_q;
  assign LAT_D    = lat_d_q;
  assign LAT_EN   = lat_en_q;
  assign LAT_ARST = lat_arst_q;
  assign BUSY     = busy_q;
  assign SHADOW   = shadow_q;

endmodule

// File: tb/tb_latch_wr_sched.sv
// Directed bench for latch_wr_sched: one ENW=1 instance and one ENW=3 instance.
module tb_latch_wr_sched;

  logic       clk;
  logic       rst_n;

  logic [1:0] req, clr;
  logic [3:0] addr;
  logic [3:0] data;
  logic [1:0] ack;
  logic [1:0] lat_d;
  logic [3:0] lat_en, lat_arst;
  logic       busy;
  logic [7:0] shadow;

  logic [1:0] req3, clr3;
  logic [3:0] addr3;
  logic [3:0] data3;
  logic [1:0] ack3;
  logic [1:0] lat_d3;
  logic [3:0] lat_en3, lat_arst3;
  logic       busy3;
  logic [7:0] shadow3;

  int n_checks = 0;
  int n_errors = 0;

  latch_wr_sched #(.NSLOT(4), .DW(2), .ENW(1)) dut1 (
    .CLK(clk), .ARST_N(rst_n), .REQ(req), .CLR(clr), .ADDR(addr), .DATA(data),
    .ACK(ack), .LAT_D(lat_d), .LAT_EN(lat_en), .LAT_ARST(lat_arst),
    .BUSY(busy), .SHADOW(shadow)
  );

  latch_wr_sched #(.NSLOT(4), .DW(2), .ENW(3)) dut3 (
    .CLK(clk), .ARST_N(rst_n), .REQ(req3), .CLR(clr3), .ADDR(addr3), .DATA(data3),
    .ACK(ack3), .LAT_D(lat_d3), .LAT_EN(lat_en3), .LAT_ARST(lat_arst3),
    .BUSY(busy3), .SHADOW(shadow3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] ack_seq [4];
  int         n_ack;
  logic       multi;
  int         en_cnt;
  int         ack_at;
  logic [1:0] ack3_val;
  logic       bad_en;

  initial begin
    rst_n = 1'b0;
    req = 2'b00; clr = 2'b00; addr = 4'h0; data = 4'h0;
    req3 = 2'b00; clr3 = 2'b00; addr3 = 4'h0; data3 = 4'h0;

    // reset state
    #12;
    chk("rst_lat_arst", 32'(lat_arst), 32'h0000_000f);
    chk("rst_shadow", 32'(shadow), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_lat_en", 32'(lat_en), 32'h0);
    #1 rst_n = 1'b1;
    tick();
    chk("rel_lat_arst", 32'(lat_arst), 32'h0);
    chk("rel_ack", 32'(ack), 32'h0);

    // contention: both requesters write continuously from a fresh pointer
    req = 2'b11; clr = 2'b00; addr = {2'd3, 2'd0}; data = {2'b10, 2'b11};
    n_ack = 0; multi = 1'b0;
    for (int k = 0; k < 4; k++) ack_seq[k] = 2'b00;
    for (int c = 0; c < 40 && n_ack < 4; c++) begin
      tick();
      if ($countones(lat_en) > 1 || (lat_en & lat_arst) != 4'h0) multi = 1'b1;
      if (ack != 2'b00) begin
        ack_seq[n_ack] = ack;
        n_ack++;
        if (n_ack == 4) req = 2'b00;
      end
    end
    chk("cont_nack", 32'(n_ack), 32'd4);
    for (int k = 0; k < 4; k++)
      chk("cont_order", 32'(ack_seq[k]), (k % 2 == 0) ? 32'h1 : 32'h2);
    chk("cont_onehot_en", 32'(multi), 32'h0);
    tick();
    chk("cont_shadow", 32'(shadow), 32'h83);
    chk("cont_idle", 32'(busy), 32'h0);

    // ENW=1 write by requester 0 to slot 2; later input changes are ignored
    req = 2'b01; clr = 2'b00; addr = {2'd0, 2'd2}; data = {2'b00, 2'b01};
    tick();
    chk("wr_setup_d", 32'(lat_d), 32'h1);
    chk("wr_setup_en", 32'(lat_en), 32'h0);
    chk("wr_setup_busy", 32'(busy), 32'h1);
    data = 4'hf; addr = 4'h1;
    tick();
    chk("wr_enable_en", 32'(lat_en), 32'h4);
    chk("wr_enable_d", 32'(lat_d), 32'h1);
    tick();
    chk("wr_hold_en", 32'(lat_en), 32'h0);
    chk("wr_hold_d", 32'(lat_d), 32'h1);
    chk("wr_hold_ack", 32'(ack), 32'h0);
    tick();
    chk("wr_done_ack", 32'(ack), 32'h1);
    req = 2'b00;
    tick();
    chk("wr_ack_pulse", 32'(ack), 32'h0);
    chk("wr_shadow", 32'(shadow), 32'h93);
    chk("wr_lat_d_kept", 32'(lat_d), 32'h1);

    // clear by requester 1 of slot 3
    req = 2'b10; clr = 2'b10; addr = {2'd3, 2'd0}; data = 4'h0;
    tick();
    chk("clr_arst", 32'(lat_arst), 32'h8);
    chk("clr_en", 32'(lat_en), 32'h0);
    chk("clr_ack_early", 32'(ack), 32'h0);
    tick();
    chk("clr_ack", 32'(ack), 32'h2);
    chk("clr_arst_off", 32'(lat_arst), 32'h0);
    req = 2'b00; clr = 2'b00;
    tick();
    chk("clr_shadow", 32'(shadow), 32'h13);
    chk("clr_ack_pulse", 32'(ack), 32'h0);

    // reset pulse in the middle of ENABLE
    req = 2'b01; clr = 2'b00; addr = {2'd0, 2'd1}; data = {2'b00, 2'b10};
    tick();
    tick();
    chk("mid_enable_en", 32'(lat_en), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(lat_en), 32'h0);
    chk("mid_rst_arst", 32'(lat_arst), 32'hf);
    chk("mid_rst_ack", 32'(ack), 32'h0);
    chk("mid_rst_shadow", 32'(shadow), 32'h0);
    #2 rst_n = 1'b1;
    tick();
    chk("regrant_busy", 32'(busy), 32'h1);
    chk("regrant_d", 32'(lat_d), 32'h2);
    chk("regrant_arst", 32'(lat_arst), 32'h0);
    ack_at = -1;
    for (int c = 1; c <= 8 && ack_at < 0; c++) begin
      tick();
      if (ack != 2'b00) begin
        ack_at = c;
        req = 2'b00;
      end
    end
    chk("regrant_ack_at", 32'(ack_at), 32'd3);
    tick();
    chk("regrant_shadow", 32'(shadow), 32'h08);

    // ENW=3 write by requester 1 to slot 0
    req3 = 2'b10; clr3 = 2'b00; addr3 = {2'd0, 2'd0}; data3 = {2'b11, 2'b00};
    en_cnt = 0; ack_at = -1; ack3_val = 2'b00; bad_en = 1'b0;
    for (int c = 1; c <= 12 && ack_at < 0; c++) begin
      tick();
      if (lat_en3 == 4'b0001) en_cnt++;
      else if (lat_en3 != 4'b0000) bad_en = 1'b1;
      if (ack3 != 2'b00) begin
        ack_at = c;
        ack3_val = ack3;
        req3 = 2'b00;
      end
    end
    chk("enw3_en_cycles", 32'(en_cnt), 32'd3);
    chk("enw3_ack_at", 32'(ack_at), 32'd6);
    chk("enw3_ack_val", 32'(ack3_val), 32'h2);
    chk("enw3_bad_en", 32'(bad_en), 32'h0);
    tick();
    chk("enw3_shadow", 32'(shadow3), 32'h03);
    chk("enw3_d", 32'(lat_d3), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/latch_wr_sched.md
LATCH_WR_SCHED -- requirements
Module: latch_wr_sched

Interface
REQ-001 Parameter NSLOT, default 4: number of latch slots scheduled; fixed at 4 in this revision.
REQ-002 Parameter DW, default 2: data width of each latch slot.
REQ-003 Parameter ENW, default 1: latch enable pulse width in CLK cycles; legal range 1..4.
REQ-004 CLK  in  1  single clock; all state changes on the rising edge.
REQ-005 ARST_N  in  1  reset; asynchronous, active-low.
REQ-006 REQ  in  2  per-requester command request; level signal, held until ACK.
REQ-007 CLR  in  2  per-requester op select; 1 = clear slot, 0 = write slot.
REQ-008 ADDR  in  2*2  per-requester slot index; requester i uses bits [2i+1:2i].
REQ-009 DATA  in  2*DW  per-requester write data; requester i uses bits [DW*i+DW-1:DW*i].
REQ-010 ACK  out  2  one-cycle completion pulse to the granted requester.
REQ-011 LAT_D  out  DW  shared data bus to all latch D inputs.
REQ-012 LAT_EN  out  NSLOT  per-slot latch enable.
REQ-013 LAT_ARST  out  NSLOT  per-slot latch asynchronous clear, active-high.
REQ-014 BUSY  out  1  high in every state except IDLE.
REQ-015 SHADOW  out  NSLOT*DW  scheduler copy of the latch bank contents; slot s occupies bits [DW*s+DW-1:DW*s].

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP, ENABLE, HOLD, CLEAR and DONE.
REQ-017 In IDLE with any REQ high, the block SHALL grant one requester and register its CLR, ADDR and DATA; later changes to those inputs SHALL be ignored until ACK.
REQ-018 When both REQ bits are high, the grant SHALL go to the requester not granted most recently; the first grant after reset SHALL go to requester 0; the pointer SHALL update only on grant.
REQ-019 A granted write SHALL go IDLE->SETUP (1 cycle)->ENABLE (ENW cycles)->HOLD (1 cycle)->DONE (1 cycle)->IDLE.
REQ-020 In SETUP, LAT_D SHALL equal the registered data and all LAT_EN bits SHALL be low.
REQ-021 In ENABLE, only LAT_EN[addr] SHALL be high, and LAT_D SHALL be stable.
REQ-022 In HOLD, LAT_EN SHALL be all low and LAT_D SHALL be unchanged.
REQ-023 LAT_D SHALL change only on entry to SETUP and SHALL hold its last value otherwise.
REQ-024 A granted clear SHALL go IDLE->CLEAR (1 cycle, LAT_ARST[addr] high only)->DONE->IDLE.
REQ-025 In DONE, ACK[granted] SHALL be high for exactly one cycle.
REQ-026 In DONE, the SHADOW slot SHALL be updated: registered data for a write, zero for a clear.
REQ-027 Latency from REQ sampled in IDLE to ACK SHALL be ENW+3 cycles for a write and 2 cycles for a clear.
REQ-028 At most one LAT_EN bit SHALL be high at any time.
REQ-029 LAT_EN and LAT_ARST SHALL never be high simultaneously.
REQ-030 A REQ that falls before grant SHALL be dropped with no ACK.
REQ-031 A REQ still high in the cycle after ACK SHALL be treated as a new command.
REQ-032 An ENW outside 1..4 SHALL be rejected at elaboration.

Reset
REQ-033 ARST_N low SHALL immediately force IDLE, LAT_EN=0, ACK=0, BUSY=0, SHADOW=0, LAT_D=0, round-robin pointer=0 and LAT_ARST=all ones.
REQ-034 LAT_ARST SHALL return to all zeros on the first CLK edge after ARST_N rises.
REQ-035 A command in flight at reset SHALL be abandoned without ACK.

Structure
REQ-036 Package latch_sched_pkg SHALL hold the state enum, the NSLOT and DW defaults, and the op encoding constants (OP_WRITE=0, OP_CLEAR=1).
REQ-037 The two-way round-robin grant logic SHALL be a separate sub-module, rr_arb2, with ports REQ[1:0], GNT[1:0] and an update strobe.

Verification
REQ-038 Reset: with ARST_N low, LAT_ARST=4'b1111 and SHADOW=0; after release, LAT_ARST=0 on the first edge and ACK stays 0.
REQ-039 Write with ENW=1: REQ0, ADDR=2, DATA=2'b01. Required response: LAT_D=01 in SETUP, LAT_EN=4'b0100 for 1 cycle, ACK[0] 4 cycles after the grant, and SHADOW slot 2 = 01.
REQ-040 Contention: REQ0 and REQ1 held high with writes, starting after reset. Required response: ACK order 0,1,0,1, and never two LAT_EN bits high.
REQ-041 Clear: REQ1, CLR=1, ADDR=3. Required response: LAT_ARST=4'b1000 for 1 cycle, ACK[1] in the next cycle, and SHADOW slot 3 = 00.
REQ-042 Reset mid-ENABLE: ARST_N pulsed low. Required response: LAT_EN=0 immediately, LAT_ARST=1111, no ACK; a still-high REQ is granted again from IDLE after release.
REQ-043 ENW=3 write: LAT_EN is high for exactly 3 cycles, and ACK arrives 6 cycles after the grant.
